// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS datapath.
//
// Purpose:
//   Drives the stage-latch enables and flushes, the PC enable and the gated
//   instruction/data memory requests. It resolves memory-wait stalls
//   (ihit/dhit), load-use hazards, taken-branch/jump flushes and halt. A small
//   FSM (RUN/DDONE/HALTED) keeps a completed data access from being re-issued
//   while fetch is still outstanding.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN - adds saturating performance counters
//                        stall_cnt, dwait_cnt and lu_cnt (CNT_W bits each).
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   ihit, dhit               fetch / data access complete this cycle
//   mem_dREN, mem_dWEN       load / store in MEM stage
//   mem_halt                 HALT in MEM stage
//   ex_dREN, ex_rt           load in EX stage and its destination register
//   id_rs, id_rt, id_uses_rt source registers of the ID-stage instruction
//   ex_redirect              taken branch/jump resolved in EX
//   pc_en                    PC load enable
//   ifid/idex/exmem/memwb_en latch enables
//   ifid_flush, idex_flush   clear latch to NOP on next edge
//   iREN, dREN, dWEN         gated memory requests
//   halt                     sticky halt indication
//   stall_cnt, dwait_cnt, lu_cnt  performance counters (optional)

module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] dwait_cnt,
    output logic [CNT_W-1:0] lu_cnt,
`endif
    output logic             halt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DDONE  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   halt_q, halt_d;

    logic dmem_s;
    logic dok_s;
    logic adv_s;
    logic lu_s;

    // Hazard and advance qualifiers shared by outputs and next-state logic.
    always_comb begin
        dmem_s = mem_dREN | mem_dWEN;
        // In DDONE the data side already completed, so it no longer blocks.
        dok_s  = ~dmem_s | dhit | (state_q == DDONE);
        adv_s  = ihit & dok_s;
        lu_s   = ex_dREN & (ex_rt != {REG_W{1'b0}}) &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // Combinational pipeline controls: reset > halted > freeze > redirect > load-use > normal.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        iREN       = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        if (RST) begin
            pc_en = 1'b0;
        end else if (state_q == HALTED) begin
            pc_en = 1'b0;
        end else begin
            iREN = 1'b1;
            // A finished access must not be re-issued while waiting in DDONE.
            if (state_q == RUN) begin
                dREN = mem_dREN;
                dWEN = mem_dWEN;
            end else begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            if (!adv_s) begin
                // Whole pipe freezes; no bubble.
                pc_en = 1'b0;
            end else if (ex_redirect) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_s) begin
                // Hold PC and IF/ID, inject one bubble into ID/EX.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // Next-state and sticky halt computation.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            RUN: begin
                if (dmem_s & dhit & ~ihit) begin
                    state_d = DDONE;
                end else if (mem_halt & adv_s) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DDONE: begin
                if (ihit) begin
                    state_d = RUN;
                end else begin
                    state_d = DDONE;
                end
            end
            HALTED: begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = RUN;
                halt_d  = 1'b0;
            end
        endcase
    end

    // State and halt registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    assign halt = halt_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, dwait_cnt_q, lu_cnt_q;
    logic             active_s;

    assign active_s = (state_q != HALTED);

    // Saturating performance counters, frozen once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            dwait_cnt_q <= {CNT_W{1'b0}};
            lu_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            if (active_s & ~adv_s & (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((state_q == RUN) & dmem_s & ~dhit & (dwait_cnt_q != {CNT_W{1'b1}})) begin
                dwait_cnt_q <= dwait_cnt_q + CNT_W'(1);
            end
            if (active_s & adv_s & lu_s & ~ex_redirect & (lu_cnt_q != {CNT_W{1'b1}})) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dwait_cnt = dwait_cnt_q;
    assign lu_cnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each step drives inputs just after the
// rising edge and pushes the hand-derived expected control vector into a
// scoreboard queue; a monitor pops and compares on the falling edge.
// Vector bit order: pc_en ifid_en idex_en exmem_en memwb_en ifid_flush
//                   idex_flush iREN dREN dWEN halt

module tb_hazard_ctrl;

    localparam logic [10:0] V_RESET  = 11'b00000_00_0_00_0;
    localparam logic [10:0] V_NORM   = 11'b11111_00_1_00_0;
    localparam logic [10:0] V_FREEZE = 11'b00000_00_1_00_0;
    localparam logic [10:0] V_LU     = 11'b00111_01_1_00_0;
    localparam logic [10:0] V_REDIR  = 11'b11111_11_1_00_0;
    localparam logic [10:0] V_HALTED = 11'b00000_00_0_00_1;
    localparam logic [10:0] B_DREN   = 11'b00000_00_0_10_0;
    localparam logic [10:0] B_DWEN   = 11'b00000_00_0_01_0;
    localparam logic [10:0] B_HALT   = 11'b00000_00_0_00_1;

    logic       CLK = 1'b0;
    logic       RST, ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       id_uses_rt, ex_redirect;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, iREN, dREN, dWEN, halt;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, dwait_cnt, lu_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [10:0] exp;
        logic        cnt_chk;
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] l;
    } entry_t;

    entry_t sb_q[$];
    logic        cnt_valid = 1'b0;
    logic [31:0] t_stall = 32'd0, t_dwait = 32'd0, t_lu = 32'd0;

    hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .dwait_cnt(dwait_cnt), .lu_cnt(lu_cnt),
`endif
        .halt(halt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [10:0] exp,
                         input logic rst, input logic ih, input logic dh,
                         input logic mdr, input logic mdw, input logic mh,
                         input logic exdr, input logic [4:0] exrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic redir);
        entry_t e;
        @(posedge CLK);
        #1;
        RST = rst; ihit = ih; dhit = dh; mem_dREN = mdr; mem_dWEN = mdw;
        mem_halt = mh; ex_dREN = exdr; ex_rt = exrt; id_rs = rs; id_rt = rt;
        id_uses_rt = uses; ex_redirect = redir;
        e.tag = tag; e.exp = exp; e.cnt_chk = cnt_valid;
        e.s = t_stall; e.d = t_dwait; e.l = t_lu;
        sb_q.push_back(e);
        // Counter tally derived from the expected vector: iREN marks an
        // active cycle, idex_en=0 a freeze, idex_en=1 with pc_en=0 a load-use.
        if (rst) begin
            cnt_valid = 1'b1;
            t_stall = 32'd0; t_dwait = 32'd0; t_lu = 32'd0;
        end else if (exp[3]) begin
            if (!exp[8]) t_stall = t_stall + 32'd1;
            if (exp[8] && !exp[10]) t_lu = t_lu + 32'd1;
            if ((exp[2] || exp[1]) && !dh) t_dwait = t_dwait + 32'd1;
        end
    endtask

    // Scoreboard monitor: compare the oldest expectation mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            entry_t e;
            e = sb_q.pop_front();
            check(e.tag, {21'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush, iREN, dREN, dWEN, halt},
                  {21'd0, e.exp});
`ifdef HAZARD_PERF_CNT_EN
            if (e.cnt_chk) begin
                check({e.tag, ".stall_cnt"}, stall_cnt, e.s);
                check({e.tag, ".dwait_cnt"}, dwait_cnt, e.d);
                check({e.tag, ".lu_cnt"}, lu_cnt, e.l);
            end
`endif
        end
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_halt = 1'b0; ex_dREN = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_redirect = 1'b0;
        repeat (2) @(posedge CLK);

        //     tag          expected                 rst  ih   dh   mdr  mdw  mh   exdr ex_rt id_rs id_rt uses redir
        drive("reset",      V_RESET,                 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("run0",       V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("run1",       V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        // Load waiting on dhit for three cycles, then completes with ihit.
        for (int i = 0; i < 3; i++)
            drive("ldwait",  V_FREEZE | B_DREN,      1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("lddone",     V_NORM | B_DREN,         1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        // Store completes while fetch is outstanding: DDONE suppresses dWEN.
        drive("st_hit",     V_FREEZE | B_DWEN,       1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("ddone0",     V_FREEZE,                1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("ddone1",     V_FREEZE,                1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("ddone_adv",  V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("back_run",   V_FREEZE | B_DWEN,       1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("st_fin",     V_NORM | B_DWEN,         1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        // Load-use on rs, then bubble in EX clears it.
        drive("lu_rs",      V_LU,                    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 5'd2, 1'b0,1'b0);
        drive("lu_after",   V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd5, 5'd2, 1'b0,1'b0);
        drive("lu_rt",      V_LU,                    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd7, 5'd3, 5'd7, 1'b1,1'b0);
        drive("rt_unused",  V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd7, 5'd3, 5'd7, 1'b0,1'b0);
        drive("lu_r0",      V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b1,1'b0);
        drive("lu_frz",     V_FREEZE,                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 5'd0, 1'b0,1'b0);
        // Redirect overrides load-use; without ihit it still freezes.
        drive("redir_lu",   V_REDIR,                 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 5'd0, 1'b0,1'b1);
        drive("redir_frz",  V_FREEZE,                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1);
        // Halt waits for adv, then becomes terminal.
        drive("halt_frz",   V_FREEZE,                1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("halt_adv",   V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("halted0",    V_HALTED,                1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("halted1",    V_HALTED,                1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,5'd4, 5'd4, 5'd0, 1'b0,1'b1);
        drive("halted2",    V_HALTED,                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        // Sync reset: halt register still set during the first reset cycle.
        drive("rst_h0",     V_RESET | B_HALT,        1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("rst_h1",     V_RESET,                 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("post_rst",   V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("post_rst1",  V_FREEZE,                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);
        drive("post_rst2",  V_NORM,                  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0);

        repeat (2) @(posedge CLK);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
